snake_move_scheduler: RTL
=========================

Name: snake_move_scheduler

Overview:
- Paces the snake: converts push-button presses into a queued direction stream and issues one move per game tick.
- Sits between the button inputs and the playfield/body logic. Drives head position, current direction and a single-cycle move strobe.
- Owns the run/pause/dead lifecycle of a game.

Parameters:
- TICK_DIV, 25000000, CLOCK cycles per move tick (minimum 4)
- GRID_W, 32, playfield width in cells
- GRID_H, 24, playfield height in cells
- POS_W, 5, width of HEAD_X/HEAD_Y; must satisfy 2**POS_W >= max(GRID_W, GRID_H)
- QUEUE_DEPTH, 2, direction command queue depth (power of two, >= 2)

Ports:
- CLOCK  in  1  system clock
- RESET  in  1  synchronous, active-high reset
- PUSH_BUTTONS  in  4  level inputs, already debounced; bit 0 right, 1 down, 2 up, 3 left
- PAUSE_BTN  in  1  level input, debounced; its rising edge toggles pause
- COLLISION  in  1  body/wall-hit flag from playfield logic; valid in the cycle MOVE_STROBE is high
- DIRECTION  out  2  current heading: 00 right, 01 down, 10 up, 11 left
- HEAD_X  out  POS_W  head column
- HEAD_Y  out  POS_W  head row
- MOVE_STROBE  out  1  one-cycle pulse, asserted in the cycle HEAD_X/HEAD_Y take their new value
- GAME_STATE  out  2  00 IDLE, 01 RUN, 10 PAUSE, 11 DEAD

Behaviour:
- Reset values: DIRECTION=00, HEAD_X=GRID_W/2, HEAD_Y=GRID_H/2, MOVE_STROBE=0, GAME_STATE=IDLE. Tick counter=0, queue empty, edge registers=0.
- Edge detect: a button event is a 0->1 transition of a PUSH_BUTTONS bit between consecutive cycles.
- If several bits rise in the same cycle, priority is 0>1>2>3, and only one command is taken per cycle.
- Command filter: each candidate is compared against the last accepted heading. That is the tail of the queue if it is non-empty, otherwise DIRECTION.
  - Dropped: same axis as that heading (same or reverse direction). Right/left is the horizontal axis, up/down the vertical.
  - Dropped: the queue is full. No overflow flag.
  - Otherwise pushed.
- Tick counter: counts 0..TICK_DIV-1 only in RUN and wraps to 0. Reaching TICK_DIV-1 is a tick. The counter is held in IDLE, PAUSE and DEAD.
- On a tick in RUN, in this cycle:
  - if the queue is non-empty, pop it into DIRECTION;
  - step the head one cell in the new DIRECTION;
  - register the new position and assert MOVE_STROBE in the next cycle.
- Move latency: 1 cycle from tick to MOVE_STROBE.
- Wrap-around: right from GRID_W-1 goes to 0; left from 0 goes to GRID_W-1; down from GRID_H-1 goes to 0; up from 0 goes to GRID_H-1.
- State machine:
  - IDLE -> RUN on any accepted command. That command is pushed, and the counter starts from 0.
  - RUN -> PAUSE on a PAUSE_BTN rising edge. PAUSE -> RUN on the next rising edge; the counter resumes from its held value.
  - RUN -> DEAD when COLLISION=1 in a MOVE_STROBE cycle. Head and DIRECTION freeze.
  - DEAD -> IDLE only via RESET.
- Commands are accepted in RUN only (IDLE accepts only the starting command described above). Presses in PAUSE and DEAD are ignored and the queue is held.
- Simultaneous events:
  - Tick and push in the same cycle: the pop uses the old queue contents, and the push lands after the pop.
  - Pause edge and tick in the same cycle: the tick is completed first, then PAUSE is entered.
  - COLLISION outside a MOVE_STROBE cycle is ignored.
- RESET mid-game: all state returns to its reset value in the next cycle, and the queue is flushed.

Optional Feature:
- Macro: SNAKE_SPEEDUP_EN.
- Defined:
  - adds input GROW (1 bit, a pulse from the playfield when food is eaten);
  - each GROW pulse in RUN reduces the effective tick period by TICK_DIV/16, saturating at TICK_DIV/4;
  - RESET restores TICK_DIV.
- Undefined: no GROW port, and the period is fixed at TICK_DIV.

Decomposition:
- Shared package snake_pkg:
  - direction typedef/constants DIR_RIGHT=00, DIR_DOWN=01, DIR_UP=10, DIR_LEFT=11;
  - game-state constants GS_IDLE, GS_RUN, GS_PAUSE, GS_DEAD;
  - function is_horizontal(dir).
- Sub-module dir_cmd_queue: a small synchronous FIFO (push, pop, full, empty, tail output), depth QUEUE_DEPTH.

Test Plan:
- Reset, then press bit 0: GAME_STATE=01 next cycle. First MOVE_STROBE after TICK_DIV cycles with HEAD_X=17, HEAD_Y=12 (defaults), DIRECTION=00.
- In RUN heading right, press bit 3 (left): dropped, DIRECTION stays 00. Press bit 1 then bit 3 within one tick: the next two strobes show DIRECTION=01 then 11.
- Press three valid alternating commands within one tick with QUEUE_DEPTH=2: the third is dropped and exactly two headings are applied over the next two ticks.
- Place the head at X=31 heading right and tick: HEAD_X=0. At Y=0 heading up and tick: HEAD_Y=23.
- PAUSE_BTN edge mid-interval: no MOVE_STROBE for 1000 cycles, then a second edge resumes. The strobe arrives after exactly the remaining count.
- COLLISION=1 with MOVE_STROBE: GAME_STATE=11 and head frozen. Button presses have no effect until RESET, after which all outputs return to their reset values.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared types for the snake move scheduler: headings, game lifecycle states
// and the axis helper used by the command filter.
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_RIGHT = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_UP    = 2'b10,
    DIR_LEFT  = 2'b11
  } dir_t;

  typedef enum logic [1:0] {
    GS_IDLE  = 2'b00,
    GS_RUN   = 2'b01,
    GS_PAUSE = 2'b10,
    GS_DEAD  = 2'b11
  } game_state_t;

  function automatic logic is_horizontal(input dir_t dir);
    return (dir == DIR_RIGHT) || (dir == DIR_LEFT);
  endfunction

endpackage

// File: rtl/dir_cmd_queue.sv
// Small synchronous FIFO of pending headings. Exposes both the oldest entry
// (next heading to apply) and the newest one (reference for the filter).
module dir_cmd_queue
  import snake_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic CLOCK,
  input  logic RESET,
  input  logic push,
  input  logic pop,
  input  dir_t push_dir,
  output dir_t head_dir,
  output dir_t tail_dir,
  output logic full,
  output logic empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   PTR_INC  = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] IDX_ONE  = PTR_W'(1);

  dir_t             mem [DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic [PTR_W-1:0] tail_idx;

  // Extra pointer bit tells a full queue from an empty one.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                    (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign tail_idx = wr_ptr[PTR_W-1:0] - IDX_ONE;
  assign head_dir = mem[rd_ptr[PTR_W-1:0]];
  assign tail_dir = mem[tail_idx];

  // NOTE: all clocked state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)  wr_ptr <= wr_ptr + PTR_INC;
      if (pop  && !empty) rd_ptr <= rd_ptr + PTR_INC;
    end
  end

  // NOTE: the storage array has no reset; the pointers alone say which
  // entries are valid, so flushing the queue only clears the pointers.
  always_ff @(posedge CLOCK) begin
    if (push && !full) mem[wr_ptr[PTR_W-1:0]] <= push_dir;
  end

endmodule

// File: rtl/snake_move_scheduler.sv
// Turns button presses into queued headings and steps the snake head once per
// tick; owns the IDLE/RUN/PAUSE/DEAD lifecycle. SNAKE_SPEEDUP_EN adds GROW.
module snake_move_scheduler
  import snake_pkg::*;
#(
  parameter int TICK_DIV    = 25000000,
  parameter int GRID_W      = 32,
  parameter int GRID_H      = 24,
  parameter int POS_W       = 5,
  parameter int QUEUE_DEPTH = 2
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic [3:0]       PUSH_BUTTONS,
  input  logic             PAUSE_BTN,
  input  logic             COLLISION,
`ifdef SNAKE_SPEEDUP_EN
  input  logic             GROW,
`endif
  output logic [1:0]       DIRECTION,
  output logic [POS_W-1:0] HEAD_X,
  output logic [POS_W-1:0] HEAD_Y,
  output logic             MOVE_STROBE,
  output logic [1:0]       GAME_STATE
);

  localparam int CNT_W = $clog2(TICK_DIV + 1);
  localparam logic [CNT_W-1:0] PERIOD_MAX = CNT_W'(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [POS_W-1:0] X_RESET    = POS_W'(GRID_W / 2);
  localparam logic [POS_W-1:0] Y_RESET    = POS_W'(GRID_H / 2);
  localparam logic [POS_W-1:0] X_LAST     = POS_W'(GRID_W - 1);
  localparam logic [POS_W-1:0] Y_LAST     = POS_W'(GRID_H - 1);
  localparam logic [POS_W-1:0] POS_ONE    = POS_W'(1);

  game_state_t      state, state_nx;
  dir_t             dir_q, new_dir, cand_dir, last_dir, q_head, q_tail;
  logic [POS_W-1:0] head_x, head_y, head_x_nx, head_y_nx;
  logic [CNT_W-1:0] tick_cnt, tick_cnt_nx, period;
  logic [3:0]       btn_q, rise;
  logic             pause_q, pause_edge, cand_valid, dead_now, tick;
  logic             push, pop, q_full, q_empty, move_strobe;

  dir_cmd_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
    .CLOCK    (CLOCK),
    .RESET    (RESET),
    .push     (push),
    .pop      (pop),
    .push_dir (cand_dir),
    .head_dir (q_head),
    .tail_dir (q_tail),
    .full     (q_full),
    .empty    (q_empty)
  );

`ifdef SNAKE_SPEEDUP_EN
  localparam logic [CNT_W-1:0] PERIOD_MIN  = CNT_W'(TICK_DIV / 4);
  localparam logic [CNT_W-1:0] PERIOD_STEP = CNT_W'(TICK_DIV / 16);

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      period <= PERIOD_MAX;
    end else if (GROW && state == GS_RUN) begin
      period <= (period < PERIOD_MIN + PERIOD_STEP) ? PERIOD_MIN
                                                    : period - PERIOD_STEP;
    end
  end
`else
  assign period = PERIOD_MAX;
`endif

  // NOTE: every signal driven here gets a default first, so no path through
  // the block leaves one unassigned and no latch is inferred.
  always_comb begin
    rise       = PUSH_BUTTONS & ~btn_q;
    pause_edge = PAUSE_BTN & ~pause_q;
    cand_valid = |rise;
    cand_dir   = DIR_RIGHT;
    if      (rise[0]) cand_dir = DIR_RIGHT;
    else if (rise[1]) cand_dir = DIR_DOWN;
    else if (rise[2]) cand_dir = DIR_UP;
    else if (rise[3]) cand_dir = DIR_LEFT;

    last_dir = q_empty ? dir_q : q_tail;
    // A collision is reported against the move just made, even if a pause
    // edge arrived together with that move's tick.
    dead_now = move_strobe && COLLISION &&
               (state == GS_RUN || state == GS_PAUSE);
    tick     = (state == GS_RUN) && !dead_now && (tick_cnt >= period - CNT_ONE);

    // The starting press in IDLE has nothing to conflict with, so any
    // direction (including right) starts the game.
    push = 1'b0;
    if (state == GS_IDLE)
      push = cand_valid;
    else if (state == GS_RUN)
      push = cand_valid && !q_full && !dead_now &&
             (is_horizontal(cand_dir) != is_horizontal(last_dir));
    pop = tick && !q_empty;

    new_dir   = q_empty ? dir_q : q_head;
    head_x_nx = head_x;
    head_y_nx = head_y;
    case (new_dir)
      DIR_RIGHT: head_x_nx = (head_x == X_LAST) ? '0 : head_x + POS_ONE;
      DIR_LEFT:  head_x_nx = (head_x == '0) ? X_LAST : head_x - POS_ONE;
      DIR_DOWN:  head_y_nx = (head_y == Y_LAST) ? '0 : head_y + POS_ONE;
      DIR_UP:    head_y_nx = (head_y == '0) ? Y_LAST : head_y - POS_ONE;
      default:   ;
    endcase

    state_nx    = state;
    tick_cnt_nx = tick_cnt;
    case (state)
      GS_IDLE: begin
        tick_cnt_nx = '0;
        if (push) state_nx = GS_RUN;
      end
      GS_RUN: begin
        if (dead_now) begin
          state_nx = GS_DEAD;
        end else begin
          tick_cnt_nx = tick ? '0 : tick_cnt + CNT_ONE;
          if (pause_edge) state_nx = GS_PAUSE;
        end
      end
      GS_PAUSE: begin
        if (dead_now)        state_nx = GS_DEAD;
        else if (pause_edge) state_nx = GS_RUN;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state       <= GS_IDLE;
      tick_cnt    <= '0;
      btn_q       <= '0;
      pause_q     <= 1'b0;
      dir_q       <= DIR_RIGHT;
      head_x      <= X_RESET;
      head_y      <= Y_RESET;
      move_strobe <= 1'b0;
    end else begin
      state       <= state_nx;
      tick_cnt    <= tick_cnt_nx;
      btn_q       <= PUSH_BUTTONS;
      pause_q     <= PAUSE_BTN;
      move_strobe <= tick;
      if (tick) begin
        dir_q  <= new_dir;
        head_x <= head_x_nx;
        head_y <= head_y_nx;
      end
    end
  end

  assign DIRECTION   = dir_q;
  assign HEAD_X      = head_x;
  assign HEAD_Y      = head_y;
  assign MOVE_STROBE = move_strobe;
  assign GAME_STATE  = state;

endmodule
